// File: rtl/ic_fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
package ic_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Address width for a register file of the given depth (never below 1 bit).
    function automatic int unsigned fifo_aw(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ic_fifo_sync_ext_dpram.sv
// Flop-based register file: synchronous write port, asynchronous read port.
module ic_dpram_rf
    import ic_fifo_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = fifo_aw(DEPTH)
) (
    input  logic          i_CLK,
    input  logic          i_WE,
    input  logic [AW-1:0] i_WA,
    input  logic [DW-1:0] i_WD,
    input  logic [AW-1:0] i_RA,
    output logic [DW-1:0] o_RD
);

    logic [DW-1:0] r_mem [DEPTH];

    // Storage is intentionally not reset; stale entries are unreachable via the pointers.
    always_ff @(posedge i_CLK) begin
        if (i_WE) begin
            r_mem[i_WA] <= i_WD;
        end
    end

    assign o_RD = r_mem[i_RA];

endmodule

// File: rtl/ic_fifo_sync_ext.sv
// Single-clock FIFO with level flags, guarded push/pop, sticky error flags and STD/FWFT read modes.
module ic_fifo_sync_ext
    import ic_fifo_pkg::*;
#(
    parameter int unsigned DW     = 16,
    parameter int unsigned DEPTH  = 8,
    parameter fifo_mode_e  MODE   = FIFO_STD,
    parameter int unsigned AF_LVL = DEPTH - 2,
    parameter int unsigned AE_LVL = 2,
    localparam int unsigned AW    = fifo_aw(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_n,
    input  logic                 i_WEN,
    input  logic signed [DW-1:0] i_DI,
    input  logic                 i_REN,
    input  logic                 i_ERR_CLR,
    output logic signed [DW-1:0] o_DO,
    output logic                 o_VALID,
    output logic        [CW-1:0] o_CNTR,
    output logic                 o_FULL,
    output logic                 o_EMPTY,
    output logic                 o_AFULL,
    output logic                 o_AEMPTY,
    output logic                 o_OVF,
    output logic                 o_UDF
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "ic_fifo_sync_ext: DEPTH must be a power of two >= 2");
    end
    if ((AF_LVL < 1) || (AF_LVL > DEPTH)) begin : g_bad_af
        $fatal(1, "ic_fifo_sync_ext: AF_LVL out of range");
    end
    if (AE_LVL >= DEPTH) begin : g_bad_ae
        $fatal(1, "ic_fifo_sync_ext: AE_LVL out of range");
    end

    logic [AW-1:0] r_wa;
    logic [AW-1:0] r_ra;
    logic [CW-1:0] r_cntr;
    logic          r_ovf;
    logic          r_udf;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [DW-1:0] w_rd;

    assign w_full   = (r_cntr == CW'(DEPTH));
    assign w_empty  = (r_cntr == '0);
    assign w_wr_acc = i_WEN & ~w_full;
    assign w_rd_acc = i_REN & ~w_empty;

    ic_dpram_rf #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_CLK (i_CLK),
        .i_WE  (w_wr_acc),
        .i_WA  (r_wa),
        .i_WD  (i_DI),
        .i_RA  (r_ra),
        .o_RD  (w_rd)
    );

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_wa   <= '0;
            r_ra   <= '0;
            r_cntr <= '0;
        end else begin
            if (w_wr_acc) r_wa <= r_wa + AW'(1);
            if (w_rd_acc) r_ra <= r_ra + AW'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cntr <= r_cntr + CW'(1);
                2'b01:   r_cntr <= r_cntr - CW'(1);
                default: r_cntr <= r_cntr;
            endcase
        end
    end

    // Sticky errors: a new violation in the clear cycle keeps the flag set.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (i_WEN & w_full)  | (r_ovf & ~i_ERR_CLR);
            r_udf <= (i_REN & w_empty) | (r_udf & ~i_ERR_CLR);
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic signed [DW-1:0] r_do;
        logic                 r_valid;

        always_ff @(posedge i_CLK or negedge i_RST_n) begin
            if (!i_RST_n) begin
                r_do    <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_acc;
                if (w_rd_acc) r_do <= w_rd;
            end
        end

        assign o_DO    = r_do;
        assign o_VALID = r_valid;
    end else begin : g_fwft
        // Head word is presented directly; forced to zero while empty so reset shows 0.
        assign o_DO    = w_empty ? '0 : w_rd;
        assign o_VALID = ~w_empty;
    end

    assign o_CNTR   = r_cntr;
    assign o_FULL   = w_full;
    assign o_EMPTY  = w_empty;
    assign o_AFULL  = (r_cntr >= CW'(AF_LVL));
    assign o_AEMPTY = (r_cntr <= CW'(AE_LVL));
    assign o_OVF    = r_ovf;
    assign o_UDF    = r_udf;

endmodule
